// File: rtl/sprite_grid_ctrl.sv
// sprite_grid_ctrl
//   Moves one sprite on a tile grid using four debounced direction buttons.
//   Button priority is Up > Dn > Lt > Rt. A press steps at once, steps again
//   after c_REPEAT_DELAY cycles, and then every c_REPEAT_RATE cycles.
//   The block also reports blocked moves and the facing direction, accepts a
//   position load and a freeze input, and drives a registered draw-enable
//   with sprite-local pixel offsets for an external bitmap ROM.
//
//   Ports
//     i_Clk, i_Rst                     clock, async active-high reset
//     i_Up/i_Dn/i_Lt/i_Rt              direction buttons (level)
//     i_Freeze                         hold position, ignore buttons
//     i_Load, i_Load_Col/Row           one-cycle position load (clamped to grid)
//     i_Col/Row_Count_Div              current pixel being scanned
//     o_Tile_Col/Row, o_Pix_X/Y        sprite position in tiles / pixels
//     o_Facing                         0 up, 1 down, 2 left, 3 right
//     o_Move_Pulse, o_Blocked          one-cycle step outcome pulses
//     o_Draw_En, o_Sprite_Col/Row      registered sprite hit and offsets
//
//   state  | meaning
//   IDLE   | no direction held; next active direction steps immediately
//   FIRST  | stepped on press, waiting for the initial repeat delay
//   REPEAT | auto-repeating at c_REPEAT_RATE
module sprite_grid_ctrl #(
  parameter int c_TILE_SIZE    = 32,
  parameter int c_GRID_COLS    = 20,
  parameter int c_GRID_ROWS    = 15,
  parameter int c_START_COL    = 9,
  parameter int c_START_ROW    = 14,
  parameter int c_REPEAT_DELAY = 12500000,
  parameter int c_REPEAT_RATE  = 2550000,
  parameter int c_PIX_W        = 10,
  parameter int c_TW = $clog2((c_GRID_COLS > c_GRID_ROWS) ? c_GRID_COLS : c_GRID_ROWS)
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_Up,
  input  logic                           i_Dn,
  input  logic                           i_Lt,
  input  logic                           i_Rt,
  input  logic                           i_Freeze,
  input  logic                           i_Load,
  input  logic [c_TW-1:0]                i_Load_Col,
  input  logic [c_TW-1:0]                i_Load_Row,
  input  logic [c_PIX_W-1:0]             i_Col_Count_Div,
  input  logic [c_PIX_W-1:0]             i_Row_Count_Div,
  output logic [c_TW-1:0]                o_Tile_Col,
  output logic [c_TW-1:0]                o_Tile_Row,
  output logic [c_PIX_W-1:0]             o_Pix_X,
  output logic [c_PIX_W-1:0]             o_Pix_Y,
  output logic [1:0]                     o_Facing,
  output logic                           o_Move_Pulse,
  output logic                           o_Blocked,
  output logic                           o_Draw_En,
  output logic [$clog2(c_TILE_SIZE)-1:0] o_Sprite_Col,
  output logic [$clog2(c_TILE_SIZE)-1:0] o_Sprite_Row
);

  localparam int c_TS_W = $clog2(c_TILE_SIZE);
  localparam logic [c_TW-1:0] c_MAX_COL = c_TW'(c_GRID_COLS - 1);
  localparam logic [c_TW-1:0] c_MAX_ROW = c_TW'(c_GRID_ROWS - 1);
  // Timer is a down-counter; loading N-1 makes the terminal count land
  // exactly N edges after the step that loaded it.
  localparam logic [31:0] c_DELAY_LD = 32'(c_REPEAT_DELAY - 1);
  localparam logic [31:0] c_RATE_LD  = 32'(c_REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        dir_vld, prev_vld, dir_changed, step, can_move;
  logic [1:0]  dir, prev_dir;

  always_comb begin
    dir_vld = i_Up | i_Dn | i_Lt | i_Rt;
    if (i_Up)      dir = 2'd0;
    else if (i_Dn) dir = 2'd1;
    else if (i_Lt) dir = 2'd2;
    else           dir = 2'd3;
    dir_changed = !prev_vld || (prev_dir != dir);
  end

  always_comb begin
    case (dir)
      2'd0:    can_move = (o_Tile_Row != '0);
      2'd1:    can_move = (o_Tile_Row < c_MAX_ROW);
      2'd2:    can_move = (o_Tile_Col != '0);
      default: can_move = (o_Tile_Col < c_MAX_COL);
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      prev_vld <= 1'b0;
      prev_dir <= 2'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      prev_vld <= dir_vld;
      prev_dir <= dir;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step      = 1'b0;
    if (i_Load || i_Freeze || !dir_vld) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          step      = 1'b1;
          state_nxt = FIRST;
          cnt_nxt   = c_DELAY_LD;
        end
        FIRST, REPEAT: begin
          if (dir_changed) begin
            step      = 1'b1;
            state_nxt = FIRST;
            cnt_nxt   = c_DELAY_LD;
          end else if (cnt == '0) begin
            step      = 1'b1;
            state_nxt = REPEAT;
            cnt_nxt   = c_RATE_LD;
          end else begin
            cnt_nxt = cnt - 32'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Tile_Col   <= c_TW'(c_START_COL);
      o_Tile_Row   <= c_TW'(c_START_ROW);
      o_Facing     <= 2'd0;
      o_Move_Pulse <= 1'b0;
      o_Blocked    <= 1'b0;
    end else begin
      o_Move_Pulse <= 1'b0;
      o_Blocked    <= 1'b0;
      if (i_Load) begin
        o_Tile_Col <= (i_Load_Col > c_MAX_COL) ? c_MAX_COL : i_Load_Col;
        o_Tile_Row <= (i_Load_Row > c_MAX_ROW) ? c_MAX_ROW : i_Load_Row;
      end else if (step) begin
        o_Facing <= dir;
        if (can_move) begin
          o_Move_Pulse <= 1'b1;
          case (dir)
            2'd0:    o_Tile_Row <= o_Tile_Row - c_TW'(1);
            2'd1:    o_Tile_Row <= o_Tile_Row + c_TW'(1);
            2'd2:    o_Tile_Col <= o_Tile_Col - c_TW'(1);
            default: o_Tile_Col <= o_Tile_Col + c_TW'(1);
          endcase
        end else begin
          o_Blocked <= 1'b1;
        end
      end
    end
  end

  assign o_Pix_X = c_PIX_W'(o_Tile_Col) << c_TS_W;
  assign o_Pix_Y = c_PIX_W'(o_Tile_Row) << c_TS_W;

  // One extra bit so the sprite's far edge never wraps at the screen edge.
  logic [c_PIX_W:0] col_e, row_e, x_lo, x_hi, y_lo, y_hi;
  logic             in_sprite;

  always_comb begin
    col_e     = {1'b0, i_Col_Count_Div};
    row_e     = {1'b0, i_Row_Count_Div};
    x_lo      = {1'b0, o_Pix_X};
    y_lo      = {1'b0, o_Pix_Y};
    x_hi      = x_lo + (c_PIX_W + 1)'(c_TILE_SIZE);
    y_hi      = y_lo + (c_PIX_W + 1)'(c_TILE_SIZE);
    in_sprite = (col_e >= x_lo) && (col_e < x_hi) && (row_e >= y_lo) && (row_e < y_hi);
  end

  // The sprite origin is tile-aligned, so the offset is just the low bits.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Draw_En    <= 1'b0;
      o_Sprite_Col <= '0;
      o_Sprite_Row <= '0;
    end else begin
      o_Draw_En    <= in_sprite;
      o_Sprite_Col <= in_sprite ? i_Col_Count_Div[c_TS_W-1:0] : '0;
      o_Sprite_Row <= in_sprite ? i_Row_Count_Div[c_TS_W-1:0] : '0;
    end
  end

endmodule
